// File: rtl/shift_arbiter_pkg.sv
// rtl/shift_arbiter_pkg.sv - shared encodings and types for the shift arbiter slice
package shift_arbiter_pkg;

  localparam logic DIR_RIGHT   = 1'b0;
  localparam logic DIR_LEFT    = 1'b1;
  localparam logic SHIFT_LOGIC = 1'b0;
  localparam logic SHIFT_ARITH = 1'b1;

  localparam int REQ_IDX_W = 1;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;
  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rsp_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amount;
    logic       dir;
    logic       arith;
  } shift_op_t;

endpackage

// File: rtl/barrel_shifter_8bit.sv
// rtl/barrel_shifter_8bit.sv - combinational 8-bit shifter, logical/arithmetic right, logical left
module barrel_shifter_8bit
  import shift_arbiter_pkg::*;
(
  input  logic [7:0] data,
  input  logic [2:0] amount,
  input  logic       dir,
  input  logic       arith,
  output logic [7:0] result
);

  logic        fill;
  logic [15:0] ext;

  always_comb begin
    // Sign fill applies to right shifts only; left shifts always bring in zeros.
    fill = (dir == DIR_RIGHT) && (arith == SHIFT_ARITH) && data[7];
    ext  = {{8{fill}}, data} >> amount;
    if (dir == DIR_LEFT) begin
      result = data << amount;
    end else begin
      result = ext[7:0];
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-requester arbiter sharing one barrel shifter, registered tagged response
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_data,
  input  logic [2:0]       req0_amount,
  input  logic             req0_dir,
  input  logic             req0_arith,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_data,
  input  logic [2:0]       req1_amount,
  input  logic             req1_dir,
  input  logic             req1_arith,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [0:0]       rsp_src,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rsp_state_t state, state_nxt;
  req_idx_t   grant, last_grant;
  logic       can_accept, accept;
  shift_op_t  op_sel;
  logic [7:0] shift_result;

  // Round-robin hands contention to whoever did not win last; fixed mode favours requester 0.
  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) begin
      if (RR_EN != 0) begin
        grant = (last_grant == REQ0) ? REQ1 : REQ0;
      end else begin
        grant = REQ0;
      end
    end else if (req1_valid) begin
      grant = REQ1;
    end
  end

  always_comb begin
    if (grant == REQ1) begin
      op_sel = '{data: req1_data, amount: req1_amount, dir: req1_dir, arith: req1_arith};
    end else begin
      op_sel = '{data: req0_data, amount: req0_amount, dir: req0_dir, arith: req0_arith};
    end
  end

  barrel_shifter_8bit u_shifter (
    .data   (op_sel.data),
    .amount (op_sel.amount),
    .dir    (op_sel.dir),
    .arith  (op_sel.arith),
    .result (shift_result)
  );

  assign can_accept = (state == ST_IDLE) || rsp_ready;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_HOLD;
      ST_HOLD: if (!accept && rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid  = (state == ST_HOLD);
    req0_ready = can_accept && (grant == REQ0);
    req1_ready = can_accept && (grant == REQ1);
  end

  // Response payload and priority pointer only move on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data   <= 8'h00;
      rsp_src    <= REQ0;
      last_grant <= REQ1;
    end else if (accept) begin
      rsp_data   <= shift_result;
      rsp_src    <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_valid && rsp_ready && (op_count != CNT_MAX)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - table-driven scoreboard bench for shift_arbiter
module tb_shift_arbiter;

  typedef struct packed {
    logic       v0;
    logic [7:0] d0;
    logic [2:0] a0;
    logic       dir0;
    logic       ar0;
    logic       v1;
    logic [7:0] d1;
    logic [2:0] a1;
    logic       dir1;
    logic       ar1;
    logic       rr;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req1_valid, req0_dir, req1_dir, req0_arith, req1_arith, rsp_ready;
  logic [7:0] req0_data, req1_data;
  logic [2:0] req0_amount, req1_amount;

  logic rr_r0, rr_r1, rr_valid;
  logic [7:0] rr_data;
  logic [0:0] rr_src;
  logic [15:0] rr_count;
  logic fp_r0, fp_r1, fp_valid;
  logic [7:0] fp_data;
  logic [0:0] fp_src;
  logic [15:0] fp_count;
  logic st_r0, st_r1, st_valid;
  logic [7:0] st_data;
  logic [0:0] st_src;
  logic [1:0] st_count;

  int checks = 0;
  int failures = 0;
  rsp_t sb[$];
  logic m_last;
  int m_count;
  vec_t tbl[12];

  always #5 clk = ~clk;

  shift_arbiter #(.RR_EN(1), .CNT_W(16)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_r0), .req0_data(req0_data),
    .req0_amount(req0_amount), .req0_dir(req0_dir), .req0_arith(req0_arith),
    .req1_valid(req1_valid), .req1_ready(rr_r1), .req1_data(req1_data),
    .req1_amount(req1_amount), .req1_dir(req1_dir), .req1_arith(req1_arith),
    .rsp_valid(rr_valid), .rsp_ready(rsp_ready), .rsp_data(rr_data),
    .rsp_src(rr_src), .op_count(rr_count)
  );

  shift_arbiter #(.RR_EN(0), .CNT_W(16)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_data(req0_data),
    .req0_amount(req0_amount), .req0_dir(req0_dir), .req0_arith(req0_arith),
    .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_data(req1_data),
    .req1_amount(req1_amount), .req1_dir(req1_dir), .req1_arith(req1_arith),
    .rsp_valid(fp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_data),
    .rsp_src(fp_src), .op_count(fp_count)
  );

  shift_arbiter #(.RR_EN(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(st_r0), .req0_data(req0_data),
    .req0_amount(req0_amount), .req0_dir(req0_dir), .req0_arith(req0_arith),
    .req1_valid(req1_valid), .req1_ready(st_r1), .req1_data(req1_data),
    .req1_amount(req1_amount), .req1_dir(req1_dir), .req1_arith(req1_arith),
    .rsp_valid(st_valid), .rsp_ready(rsp_ready), .rsp_data(st_data),
    .rsp_src(st_src), .op_count(st_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, predict grant from the bench's own arbitration model, then check the registered response.
  task automatic apply(input vec_t v);
    logic mv, ca, g, acc;
    req0_valid = v.v0; req0_data = v.d0; req0_amount = v.a0; req0_dir = v.dir0; req0_arith = v.ar0;
    req1_valid = v.v1; req1_data = v.d1; req1_amount = v.a1; req1_dir = v.dir1; req1_arith = v.ar1;
    rsp_ready  = v.rr;
    #1;
    mv  = (sb.size() != 0);
    ca  = !mv || v.rr;
    g   = (v.v0 && v.v1) ? ~m_last : v.v1;
    acc = ca && (v.v0 || v.v1);
    if (v.v0 || !ca) check("req0_ready", {31'd0, rr_r0}, {31'd0, ca && !g});
    if (v.v1 || !ca) check("req1_ready", {31'd0, rr_r1}, {31'd0, ca && g});
    if (v.v0 && v.v1 && v.rr) begin
      check("fixed_req0_ready", {31'd0, fp_r0}, 32'd1);
      check("fixed_req1_ready", {31'd0, fp_r1}, 32'd0);
    end
    if (mv && v.rr) begin
      void'(sb.pop_front());
      m_count++;
    end
    if (acc) begin
      sb.push_back('{src: g, data: v.exp_data});
      m_last = g;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", {31'd0, rr_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("rsp_data", {24'd0, rr_data}, {24'd0, sb[0].data});
      check("rsp_src", {31'd0, rr_src}, {31'd0, sb[0].src});
    end
    check("op_count", {16'd0, rr_count}, m_count);
    check("sat_op_count", {30'd0, st_count}, (m_count > 3) ? 32'd3 : m_count);
  endtask

  initial begin
    //            v0 d0     a0   dr ar  v1 d1     a1   dr ar  rr exp
    tbl[0]  = '{1, 8'h01, 3'd1, 1, 0, 1, 8'h80, 3'd7, 0, 0, 1, 8'h02};
    tbl[1]  = '{1, 8'h01, 3'd1, 1, 0, 1, 8'h80, 3'd7, 0, 0, 1, 8'h01};
    tbl[2]  = '{1, 8'h01, 3'd1, 1, 0, 1, 8'h80, 3'd7, 0, 0, 1, 8'h02};
    tbl[3]  = '{1, 8'h01, 3'd1, 1, 0, 1, 8'h80, 3'd7, 0, 0, 1, 8'h01};
    tbl[4]  = '{1, 8'h96, 3'd3, 0, 1, 0, 8'h00, 3'd0, 0, 0, 1, 8'hF2};
    tbl[5]  = '{1, 8'h96, 3'd3, 0, 0, 0, 8'h00, 3'd0, 0, 0, 1, 8'h12};
    tbl[6]  = '{1, 8'h96, 3'd3, 1, 0, 0, 8'h00, 3'd0, 0, 0, 1, 8'hB0};
    tbl[7]  = '{0, 8'h00, 3'd0, 0, 0, 1, 8'h81, 3'd0, 0, 1, 1, 8'h81};
    tbl[8]  = '{0, 8'h00, 3'd0, 0, 0, 1, 8'h81, 3'd7, 0, 1, 1, 8'hFF};
    tbl[9]  = '{1, 8'h81, 3'd1, 1, 1, 0, 8'h00, 3'd0, 0, 0, 1, 8'h02};
    tbl[10] = '{0, 8'h00, 3'd0, 0, 0, 1, 8'hC3, 3'd2, 0, 0, 1, 8'h30};
    tbl[11] = '{0, 8'h00, 3'd0, 0, 0, 0, 8'h00, 3'd0, 0, 0, 1, 8'h00};

    rst_n = 1'b0;
    req0_valid = 0; req0_data = 0; req0_amount = 0; req0_dir = 0; req0_arith = 0;
    req1_valid = 0; req1_data = 0; req1_amount = 0; req1_dir = 0; req1_arith = 0;
    rsp_ready = 0;
    m_last = 1'b1;
    m_count = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", {31'd0, rr_valid}, 32'd0);
    check("reset_rsp_data", {24'd0, rr_data}, 32'd0);
    check("reset_rsp_src", {31'd0, rr_src}, 32'd0);
    check("reset_op_count", {16'd0, rr_count}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i]);
    check("sat_holds_at_max", {30'd0, st_count}, 32'd3);

    // Backpressure: result held stable for three stalled cycles, then accept in the releasing cycle.
    apply('{0, 8'h00, 3'd0, 0, 0, 1, 8'h0F, 3'd4, 1, 0, 1, 8'hF0});
    for (int i = 0; i < 3; i++)
      apply('{1, 8'(8'h10 + i), 3'(i), 0, 1, 1, 8'(8'hA0 + i), 3'd1, 1, 0, 0, 8'h00});
    apply('{1, 8'h55, 3'd1, 0, 0, 1, 8'h33, 3'd2, 1, 0, 1, 8'h2A});
    check("accept_on_release_src", {31'd0, rr_src}, 32'd0);

    // Asynchronous reset mid-cycle while a response is held.
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", {31'd0, rr_valid}, 32'd0);
    check("async_rst_op_count", {16'd0, rr_count}, 32'd0);
    check("async_rst_sat_count", {30'd0, st_count}, 32'd0);
    sb.delete();
    m_last = 1'b1;
    m_count = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(tbl[0]);
    check("post_reset_grant_src", {31'd0, rr_src}, 32'd0);
    apply(tbl[1]);
    apply(tbl[11]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
